// File: rtl/overture_pkg.sv
// Shared encodings for the overture CPU: instruction classes, ALU ops,
// branch condition codes, the I/O register selector and the control FSM states.
package overture_pkg;

    localparam logic [1:0] CLS_IMM  = 2'b00;
    localparam logic [1:0] CLS_CALC = 2'b01;
    localparam logic [1:0] CLS_COPY = 2'b10;
    localparam logic [1:0] CLS_COND = 2'b11;

    localparam logic [2:0] OP_OR   = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [2:0] CC_NEVER  = 3'd0;
    localparam logic [2:0] CC_EQZ    = 3'd1;
    localparam logic [2:0] CC_LTZ    = 3'd2;
    localparam logic [2:0] CC_LEZ    = 3'd3;
    localparam logic [2:0] CC_ALWAYS = 3'd4;
    localparam logic [2:0] CC_NEZ    = 3'd5;
    localparam logic [2:0] CC_GEZ    = 3'd6;
    localparam logic [2:0] CC_GTZ    = 3'd7;

    localparam logic [2:0] IO_SEL = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/overture_alu.sv
// Combinational datapath: r1/r2 logic and arithmetic ops plus the signed
// condition test on r3 used by conditional jumps.
module overture_alu
    import overture_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] cmp,
    input  logic [2:0]        op,
    input  logic [2:0]        cc,
    output logic [DATA_W-1:0] y,
    output logic              taken
);

    logic zero_s;
    logic neg_s;

    assign zero_s = (cmp == {DATA_W{1'b0}});
    assign neg_s  = cmp[DATA_W-1];

    // Arithmetic and logic result; HALT produces no value.
    always_comb begin
        case (op)
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_AND:  y = a & b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_XOR:  y = a ^ b;
            default: y = {DATA_W{1'b0}};
        endcase
    end

    // Branch decision on the sign and zero flags of cmp.
    always_comb begin
        case (cc)
            CC_NEVER:  taken = 1'b0;
            CC_EQZ:    taken = zero_s;
            CC_LTZ:    taken = neg_s;
            CC_LEZ:    taken = neg_s | zero_s;
            CC_ALWAYS: taken = 1'b1;
            CC_NEZ:    taken = ~zero_s;
            CC_GEZ:    taken = ~neg_s;
            CC_GTZ:    taken = ~neg_s & ~zero_s;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/overture_cpu_ext.sv
// Overture accumulator-style CPU with run/step/restart control, a writable
// program memory, a stalling input port and a strobed output register.
module overture_cpu_ext
    import overture_pkg::*;
#(
    parameter int  DATA_W     = 8,
    parameter int  PROG_DEPTH = 256,
    localparam int PC_W       = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              restart,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [7:0]        prog_data,
    input  logic [DATA_W-1:0] in_port,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    output logic [PC_W-1:0]   pc,
    output logic [7:0]        instr_debug,
    output logic              halted,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_reg
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [7:0]              mem_q [PROG_DEPTH];
    state_t                  state_q, state_d;
    logic [PC_W-1:0]         pc_q, pc_d;
    logic [5:0][DATA_W-1:0]  regs_q, regs_d;
    logic [DATA_W-1:0]       out_port_q, out_port_d;
    logic                    out_valid_q, out_valid_d;
    logic                    halted_q, halted_d;
    logic                    stall_q, stall_d;

    logic [7:0]              instr_s;
    logic [1:0]              cls_s;
    logic [2:0]              src_s;
    logic [2:0]              dst_s;
    logic                    exec_s;
    logic                    in_ready_s;
    logic                    prog_wr_s;
    logic [DATA_W-1:0]       alu_y_s;
    logic                    taken_s;
    logic [DATA_W-1:0]       copy_val_s;

    assign instr_s = mem_q[pc_q];
    assign cls_s   = instr_s[7:6];
    assign src_s   = instr_s[5:3];
    assign dst_s   = instr_s[2:0];

    overture_alu #(.DATA_W(DATA_W)) u_alu (
        .a     (regs_q[1]),
        .b     (regs_q[2]),
        .cmp   (regs_q[3]),
        .op    (dst_s),
        .cc    (dst_s),
        .y     (alu_y_s),
        .taken (taken_s)
    );

    // COPY source operand: register, input port, or constant zero.
    always_comb begin
        if (src_s == IO_SEL) begin
            copy_val_s = in_port;
        end else if (src_s < 3'd6) begin
            copy_val_s = regs_q[src_s];
        end else begin
            copy_val_s = {DATA_W{1'b0}};
        end
    end

    // Next-state, program counter and register-file update for one cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        regs_d      = regs_q;
        out_port_d  = out_port_q;
        out_valid_d = 1'b0;
        stall_d     = 1'b0;
        exec_s      = 1'b0;
        in_ready_s  = 1'b0;
        if (restart) begin
            state_d = ST_IDLE;
            pc_d    = {PC_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_RUN;
                    end else if (step) begin
                        state_d = ST_STEP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                // A stalled input COPY keeps executing even after run drops.
                ST_RUN: begin
                    exec_s  = run | stall_q;
                    state_d = (run | stall_q) ? ST_RUN : ST_IDLE;
                end
                ST_STEP:   exec_s  = 1'b1;
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_IDLE;
            endcase
            if (exec_s) begin
                pc_d    = pc_q + PC_ONE;
                state_d = (state_q == ST_STEP || !run) ? ST_IDLE : ST_RUN;
                case (cls_s)
                    CLS_IMM: regs_d[0] = DATA_W'(instr_s[5:0]);
                    CLS_CALC: begin
                        if (dst_s == OP_HALT) begin
                            pc_d    = pc_q;
                            state_d = ST_HALTED;
                        end else begin
                            regs_d[3] = alu_y_s;
                        end
                    end
                    CLS_COPY: begin
                        in_ready_s = (src_s == IO_SEL);
                        if (src_s == IO_SEL && !in_valid) begin
                            pc_d    = pc_q;
                            state_d = state_q;
                            stall_d = 1'b1;
                        end else if (dst_s == IO_SEL) begin
                            out_port_d  = copy_val_s;
                            out_valid_d = 1'b1;
                        end else if (dst_s < 3'd6) begin
                            regs_d[dst_s] = copy_val_s;
                        end else begin
                            regs_d = regs_q;
                        end
                    end
                    CLS_COND: begin
                        if (taken_s) begin
                            pc_d = PC_W'(regs_q[0]);
                        end else begin
                            pc_d = pc_q + PC_ONE;
                        end
                    end
                    default: pc_d = pc_q;
                endcase
            end else begin
                in_ready_s = 1'b0;
            end
        end
        halted_d = (state_d == ST_HALTED);
    end

    // Control and architectural state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= {PC_W{1'b0}};
            regs_q      <= {(6*DATA_W){1'b0}};
            out_port_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            regs_q      <= regs_d;
            out_port_q  <= out_port_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            stall_q     <= stall_d;
        end
    end

    assign prog_wr_s = prog_we && (state_q == ST_IDLE || state_q == ST_HALTED);

    // Program memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_wr_s) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // Debug readback of r0..r5; selectors 6 and 7 read zero.
    always_comb begin
        if (dbg_sel < 3'd6) begin
            dbg_reg = regs_q[dbg_sel];
        end else begin
            dbg_reg = {DATA_W{1'b0}};
        end
    end

    assign in_ready    = in_ready_s;
    assign out_port    = out_port_q;
    assign out_valid   = out_valid_q;
    assign pc          = pc_q;
    assign instr_debug = instr_s;
    assign halted      = halted_q;

endmodule

// File: tb/tb_overture_cpu_ext.sv
// Self-checking bench for overture_cpu_ext: directed scenarios followed by a
// randomized run compared against an instruction-level reference model.
module tb_overture_cpu_ext;

    logic       clk = 1'b0;
    logic       reset, run, step, restart, prog_we;
    logic [7:0] prog_addr, prog_data, in_port;
    logic       in_valid, in_ready;
    logic [7:0] out_port;
    logic       out_valid;
    logic [7:0] pc, instr_debug;
    logic       halted;
    logic [2:0] dbg_sel;
    logic [7:0] dbg_reg;

    logic        run_w, step_w, restart_w, prog_we_w;
    logic [7:0]  prog_addr_w, prog_data_w;
    logic [15:0] in_port_w;
    logic        in_valid_w, in_ready_w;
    logic [15:0] out_port_w;
    logic        out_valid_w;
    logic [7:0]  pc_w, instr_debug_w;
    logic        halted_w;
    logic [2:0]  dbg_sel_w;
    logic [15:0] dbg_reg_w;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [7:0] P031 [6] = '{8'h05, 8'h81, 8'h02, 8'h82, 8'h44, 8'h9E};
    localparam logic [7:0] P16  [9] = '{8'h00, 8'h81, 8'h01, 8'h82, 8'h45, 8'h99, 8'h44, 8'h3F, 8'h47};

    // reference model state
    logic [7:0] m_mem [256];
    logic [7:0] m_r   [6];
    logic [7:0] m_pc, m_out;
    logic       m_ov;
    int         m_mode;   // 0 idle, 1 running, 2 halted

    overture_cpu_ext #(.DATA_W(8), .PROG_DEPTH(256)) u_dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .restart(restart),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .in_port(in_port), .in_valid(in_valid), .in_ready(in_ready),
        .out_port(out_port), .out_valid(out_valid), .pc(pc),
        .instr_debug(instr_debug), .halted(halted), .dbg_sel(dbg_sel), .dbg_reg(dbg_reg)
    );

    overture_cpu_ext #(.DATA_W(16), .PROG_DEPTH(256)) u_dut16 (
        .clk(clk), .reset(reset), .run(run_w), .step(step_w), .restart(restart_w),
        .prog_we(prog_we_w), .prog_addr(prog_addr_w), .prog_data(prog_data_w),
        .in_port(in_port_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .out_port(out_port_w), .out_valid(out_valid_w), .pc(pc_w),
        .instr_debug(instr_debug_w), .halted(halted_w), .dbg_sel(dbg_sel_w), .dbg_reg(dbg_reg_w)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] sel, input logic [7:0] exp);
        dbg_sel = sel;
        #1;
        chk(tag, dbg_reg, exp);
    endtask

    task automatic step_one();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    // Runs the six-instruction output program from pc 0 in IDLE.
    task automatic run031(input string tag);
        run = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk({tag, "_ov_early"}, out_valid, 1'b0);
        end
        tick();
        chk({tag, "_ov"}, out_valid, 1'b1);
        chk({tag, "_out"}, out_port, 8'h07);
        chk({tag, "_pc"}, pc, 8'h06);
        run = 1'b0;
        tick();
        chk({tag, "_ov_pulse"}, out_valid, 1'b0);
        chk({tag, "_out_hold"}, out_port, 8'h07);
        chk({tag, "_pc_idle"}, pc, 8'h06);
    endtask

    function automatic logic [7:0] m_calc(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int x, y, r;
        x = a;
        y = b;
        case (op)
            3'd0:    r = x | y;
            3'd1:    r = ~(x & y);
            3'd2:    r = ~(x | y);
            3'd3:    r = x & y;
            3'd4:    r = x + y;
            3'd5:    r = x - y;
            default: r = x ^ y;
        endcase
        return 8'(r & 255);
    endfunction

    function automatic bit m_cond(input logic [7:0] v, input logic [2:0] code);
        int s;
        s = int'($signed(v));
        case (code)
            3'd0:    return 1'b0;
            3'd1:    return s == 0;
            3'd2:    return s < 0;
            3'd3:    return s <= 0;
            3'd4:    return 1'b1;
            3'd5:    return s != 0;
            3'd6:    return s >= 0;
            default: return s > 0;
        endcase
    endfunction

    // Advances the reference model by one clock edge using the current inputs.
    task automatic model_edge();
        logic [7:0] ins, v;
        logic [2:0] src, dst;
        bit wr_ok;
        wr_ok = (m_mode != 1);
        ins   = m_mem[m_pc];
        src   = ins[5:3];
        dst   = ins[2:0];
        m_ov  = 1'b0;
        if (restart) begin
            m_mode = 0;
            m_pc   = 8'd0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            case (ins[7:6])
                2'd0: begin
                    m_r[0] = {2'b00, ins[5:0]};
                    m_pc   = m_pc + 8'd1;
                end
                2'd1: begin
                    if (dst == 3'd7) begin
                        m_mode = 2;
                    end else begin
                        m_r[3] = m_calc(m_r[1], m_r[2], dst);
                        m_pc   = m_pc + 8'd1;
                    end
                end
                2'd2: begin
                    if (!(src == 3'd6 && !in_valid)) begin
                        if (src == 3'd6) v = in_port;
                        else if (src == 3'd7) v = 8'd0;
                        else v = m_r[src];
                        if (dst == 3'd6) begin
                            m_out = v;
                            m_ov  = 1'b1;
                        end else if (dst < 3'd6) begin
                            m_r[dst] = v;
                        end
                        m_pc = m_pc + 8'd1;
                    end
                end
                default: begin
                    if (m_cond(m_r[3], dst)) m_pc = m_r[0];
                    else m_pc = m_pc + 8'd1;
                end
            endcase
        end
        if (prog_we && wr_ok) m_mem[prog_addr] = prog_data;
    endtask

    initial begin
        logic [7:0] m_ins;
        bit exp_ready;

        reset = 1'b1; run = 1'b0; step = 1'b0; restart = 1'b0; prog_we = 1'b0;
        prog_addr = 8'd0; prog_data = 8'd0; in_port = 8'd0; in_valid = 1'b0; dbg_sel = 3'd0;
        run_w = 1'b0; step_w = 1'b0; restart_w = 1'b0; prog_we_w = 1'b0;
        prog_addr_w = 8'd0; prog_data_w = 8'd0; in_port_w = 16'd0; in_valid_w = 1'b0; dbg_sel_w = 3'd0;

        #3;
        chk("rst_pc", pc, 8'h00);
        chk("rst_out_port", out_port, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 6; i++) chk_reg("rst_reg", 3'(i), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // six-instruction output program
        for (int i = 0; i < 6; i++) load(8'(i), P031[i]);
        run031("p031");

        // SUB then conditional jump, stepped one instruction at a time
        do_restart();
        chk("p032_restart_pc", pc, 8'h00);
        load(8'd0, 8'h02); load(8'd1, 8'h81); load(8'd2, 8'h05); load(8'd3, 8'h82);
        load(8'd4, 8'h10); load(8'd5, 8'h45); load(8'd6, 8'hC2);
        for (int i = 0; i < 6; i++) step_one();
        chk("p032_pc6", pc, 8'h06);
        chk_reg("p032_r1", 3'd1, 8'h02);
        chk_reg("p032_r2", 3'd2, 8'h05);
        chk_reg("p032_r3", 3'd3, 8'hFD);
        step_one();
        chk("p032_taken", pc, 8'h10);
        tick();
        chk("p032_idle_hold", pc, 8'h10);
        do_restart();
        load(8'd0, 8'h02); load(8'd1, 8'h81); load(8'd2, 8'h82); load(8'd3, 8'h10);
        load(8'd4, 8'h45); load(8'd5, 8'hC2);
        for (int i = 0; i < 5; i++) step_one();
        chk_reg("p032_r3_zero", 3'd3, 8'h00);
        step_one();
        chk("p032_not_taken", pc, 8'h06);

        // input COPY stall, with run dropped while stalled
        do_restart();
        load(8'd0, 8'hB1);
        in_valid = 1'b0;
        run = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("p033_ready_stall", in_ready, 1'b1);
            if (i == 2) run = 1'b0;
            tick();
            chk("p033_pc_held", pc, 8'h00);
        end
        in_valid = 1'b1;
        in_port  = 8'h5A;
        chk("p033_ready_xfer", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("p033_pc_inc", pc, 8'h01);
        chk_reg("p033_r1", 3'd1, 8'h5A);
        chk("p033_ready_low", in_ready, 1'b0);
        tick();
        chk("p033_idle_pc", pc, 8'h01);

        // HALT and restart
        do_restart();
        load(8'd0, 8'h01); load(8'd1, 8'h02); load(8'd2, 8'h03); load(8'd3, 8'h47);
        run = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("p034_halted", halted, 1'b1);
        chk("p034_pc", pc, 8'h03);
        tick(); tick();
        chk("p034_pc_frozen", pc, 8'h03);
        chk("p034_still_halted", halted, 1'b1);
        run = 1'b0;
        do_restart();
        chk("p034_restart_halted", halted, 1'b0);
        chk("p034_restart_pc", pc, 8'h00);
        chk_reg("p034_r0_kept", 3'd0, 8'h03);
        chk_reg("p034_r1_kept", 3'd1, 8'h5A);

        // asynchronous reset in the middle of a run
        for (int i = 0; i < 6; i++) load(8'(i), P031[i]);
        load(8'd6, 8'h40);
        run = 1'b1;
        tick(); tick(); tick(); tick();
        #2;
        reset = 1'b1;
        run   = 1'b0;
        #1;
        chk("p035_pc", pc, 8'h00);
        chk("p035_out_port", out_port, 8'h00);
        chk("p035_out_valid", out_valid, 1'b0);
        chk("p035_halted", halted, 1'b0);
        chk_reg("p035_r0", 3'd0, 8'h00);
        chk("p035_mem_kept", instr_debug, 8'h05);
        @(negedge clk);
        reset = 1'b0;
        tick();
        run031("p035_rerun");

        // randomized run against the reference model
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int a = 0; a < 256; a++) begin
            m_mem[a] = 8'($urandom);
            load(8'(a), m_mem[a]);
        end
        for (int r = 0; r < 6; r++) m_r[r] = 8'd0;
        m_pc = 8'd0; m_out = 8'd0; m_ov = 1'b0; m_mode = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            run       = 1'b1;
            restart   = ($urandom_range(0, 63) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_port   = 8'($urandom);
            prog_we   = ($urandom_range(0, 7) == 0);
            prog_addr = 8'($urandom);
            prog_data = 8'($urandom);
            dbg_sel   = 3'($urandom_range(0, 7));
            #1;
            m_ins = m_mem[m_pc];
            exp_ready = !restart && m_mode == 1 && m_ins[7:6] == 2'd2 && m_ins[5:3] == 3'd6;
            chk("rnd_instr", instr_debug, m_ins);
            chk("rnd_in_ready", in_ready, exp_ready);
            model_edge();
            tick();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_out_port", out_port, m_out);
            chk("rnd_out_valid", out_valid, m_ov);
            chk("rnd_halted", halted, m_mode == 2);
            chk("rnd_dbg", dbg_reg, (dbg_sel < 3'd6) ? m_r[dbg_sel] : 8'd0);
        end
        run = 1'b0; restart = 1'b0; prog_we = 1'b0; in_valid = 1'b0;

        // 16-bit instance: wraparound ADD and zero-extended IMM
        for (int i = 0; i < 9; i++) begin
            prog_addr_w = 8'(i);
            prog_data_w = P16[i];
            prog_we_w   = 1'b1;
            tick();
        end
        prog_we_w = 1'b0;
        run_w     = 1'b1;
        for (int i = 0; i < 40 && !halted_w; i++) tick();
        run_w = 1'b0;
        chk("w16_halted", halted_w, 1'b1);
        chk("w16_pc", pc_w, 8'h08);
        dbg_sel_w = 3'd1; #1;
        chk("w16_r1", dbg_reg_w, 16'hFFFF);
        dbg_sel_w = 3'd2; #1;
        chk("w16_r2", dbg_reg_w, 16'h0001);
        dbg_sel_w = 3'd3; #1;
        chk("w16_r3", dbg_reg_w, 16'h0000);
        dbg_sel_w = 3'd0; #1;
        chk("w16_r0", dbg_reg_w, 16'h003F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/overture_cpu_ext.md
OVERTURE_CPU_EXT -- requirements
Module: overture_cpu_ext

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the register/ALU/port width (legal range 8..32).
REQ-002 The block SHALL have parameter PROG_DEPTH, default 256, giving the program memory words (power of two, 8-bit instructions); PC_W = clog2(PROG_DEPTH).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 run  in  1  level; execute continuously while high.
REQ-006 step  in  1  single-cycle pulse; execute exactly one instruction from IDLE.
REQ-007 restart  in  1  pulse; pc to 0 and state to IDLE, registers kept.
REQ-008 prog_we, prog_addr[PC_W], prog_data[8]  in  program memory write port.
REQ-009 in_port[DATA_W], in_valid  in; in_ready  out  input handshake.
REQ-010 out_port[DATA_W], out_valid  out  output register plus one-cycle strobe.
REQ-011 pc[PC_W], instr_debug[8], halted  out  status; dbg_sel[3] in, dbg_reg[DATA_W] out  register r0..r5 readback (sel 6/7 read 0).

Function
REQ-012 Fetch: instr_debug = mem[pc], combinational read; one instruction retires per non-stalled execute cycle.
REQ-013 Class instr[7:6]=00 IMM: r0 = zero-extended instr[5:0].
REQ-014 Class 01 CALC: r3 = r1 op r2, op instr[2:0]: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB, 6 XOR, 7 HALT (no register write); results modulo 2^DATA_W.
REQ-015 Class 10 COPY: src instr[5:3], dst instr[2:0]; 0-5 = r0-r5, 6 = I/O, src 7 reads 0, dst 7 discards.
REQ-016 Class 11 COND on r3 signed, code instr[2:0]: 0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0; taken -> pc = r0[PC_W-1:0], else pc+1.
REQ-017 pc increments modulo PROG_DEPTH (wrap from PROG_DEPTH-1 to 0).
REQ-018 in_ready SHALL be high only in an execute cycle whose instruction is COPY with src 6; no transfer -> stall (pc, regs held); transfer on in_valid&in_ready.
REQ-019 COPY with dst 6: out_port loads value at the edge; out_valid high exactly the following cycle; out_port held until next write.
REQ-020 COPY 6->6 SHALL wait for input then forward it to out_port.
REQ-021 FSM states IDLE, RUN, STEP, HALTED; execute cycles occur only in RUN and STEP.
REQ-022 IDLE: run=1 -> RUN; else step=1 -> STEP; run wins if both high.
REQ-023 RUN: run=0 -> IDLE with no instruction executed in that cycle, except a stalled input COPY, which completes first.
REQ-024 STEP: executes one instruction (stalling as needed), then -> IDLE.
REQ-025 HALT retires into HALTED with pc frozen at the HALT address and halted=1; exit only by restart or reset.
REQ-026 restart has priority over all execution from any state; prog_we is accepted only in IDLE/HALTED and ignored in RUN/STEP.

Reset
REQ-027 Reset SHALL asynchronously force state IDLE, pc 0, r0-r5 0, out_port 0, out_valid 0, halted 0.
REQ-028 Program memory contents SHALL be unaffected by reset.

Structure
REQ-029 Package overture_pkg SHALL hold class encodings, ALU op and condition codes, IO_SEL=6, and the state enum.
REQ-030 One sub-module overture_alu (combinational, parameter DATA_W: ops plus condition evaluation) SHALL be instantiated.

Verification
REQ-031 Load 05,81,02,82,44,9E; pulse run -> out_port=0x07, out_valid single pulse after the 6th instruction, pc=6.
REQ-032 r1=2, r2=5, 45 (SUB), r0=0x10, C2 -> r3=0xFD, pc=0x10; with r3=0 instead, pc increments.
REQ-033 B1 with in_valid low 3 cycles -> pc held, in_ready high throughout; in_valid=1, in_port=0x5A -> r1=0x5A, pc+1.
REQ-034 47 at address 3 -> halted=1, pc=3 held with run high; restart -> IDLE, pc=0, registers unchanged.
REQ-035 Assert reset mid-RUN -> all outputs 0 immediately; rerun program from REQ-031 -> identical output.
REQ-036 DATA_W=16: r1=0xFFFF (via copies/SUB), r2=1, ADD -> r3=0x0000; IMM 3F -> r0=0x003F.
